// File: rtl/braille_reader_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// braille_reader_sequencer
//
// Sequencing controller in front of the braille converter datapath. It turns
// a raw, bouncing "next" push-button and an optional auto-advance timer into
// a character index. It fetches that character's 6-dot cell from the
// converter and holds the cell on a registered output for the reader.
//
// Ports
//   clk        single clock
//   rst_n      asynchronous, active-low reset
//   next_btn   raw asynchronous "next" button, active high, may bounce
//   auto_en    1 = advance automatically after AUTO_PERIOD cycles in SHOW
//   conv_req   fetch request to the converter, held until conv_ack
//   conv_idx   index being fetched, stable while conv_req=1
//   conv_ack   converter response, conv_dots valid in the same cycle
//   conv_dots  dot pattern from converter (bit0 = dot1 .. bit5 = dot6)
//   dots_out   registered cell currently displayed
//   char_idx   index of the cell on dots_out
//   busy       1 while a fetch is outstanding
//   wrap       one-cycle pulse when the index wraps MSG_LEN-1 -> 0
//   state_dbg  current sequencer state (0 RESET, 1 FETCH, 2 SHOW)
//
// Converter handshake: conv_req rises together with a new conv_idx and both
// stay constant until the first clock edge that samples conv_ack=1. That
// edge captures conv_dots and drops conv_req. conv_ack seen while conv_req=0
// is ignored, and an ack on the very first request cycle is legal.
// -----------------------------------------------------------------------------
module braille_reader_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MSG_LEN         = 16,
  parameter int IDX_W           = 4,
  parameter int AUTO_PERIOD     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             next_btn,
  input  logic             auto_en,
  output logic             conv_req,
  output logic [IDX_W-1:0] conv_idx,
  input  logic             conv_ack,
  input  logic [5:0]       conv_dots,
  output logic [5:0]       dots_out,
  output logic [IDX_W-1:0] char_idx,
  output logic             busy,
  output logic             wrap,
  output logic [1:0]       state_dbg
);

  // Counter widths use N+1 so that a parameter of 1 still gives a 1-bit counter.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(AUTO_PERIOD + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(AUTO_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, debounce, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic            btn_meta;
  logic            btn_sync;
  logic            btn_deb;
  logic [DB_W-1:0] db_cnt;
  logic            btn_adv;

  // db_cnt counts consecutive cycles in which the synced level disagrees
  // with the debounced level. Any agreeing cycle restarts the count, so a
  // bounce shorter than DEBOUNCE_CYCLES never reaches btn_deb. btn_adv is
  // registered at the same edge that raises btn_deb. It is a one-cycle pulse
  // that the sequencer samples on the following edge. A release produces no
  // pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_deb  <= 1'b0;
      db_cnt   <= '0;
      btn_adv  <= 1'b0;
    end else begin
      btn_meta <= next_btn;
      btn_sync <= btn_meta;
      btn_adv  <= 1'b0;
      if (btn_sync != btn_deb) begin
        if (db_cnt == DB_LAST) begin
          btn_deb <= btn_sync;
          db_cnt  <= '0;
          btn_adv <= btn_sync;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t          state;
  logic            pending;
  logic [TM_W-1:0] auto_tmr;
  logic            tmr_expire;
  logic            advance;

  // The timer only runs in SHOW, so it can expire only in SHOW. A button
  // pulse that coincides with an expiry merges into a single advance.
  assign tmr_expire = auto_en && (auto_tmr == TM_LAST);
  assign advance    = btn_adv || tmr_expire || pending;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      conv_req <= 1'b0;
      conv_idx <= '0;
      dots_out <= '0;
      char_idx <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      pending  <= 1'b0;
      auto_tmr <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_RESET: begin
          // First edge after reset release always starts fetching index 0.
          state    <= ST_FETCH;
          conv_req <= 1'b1;
          busy     <= 1'b1;
          conv_idx <= '0;
          auto_tmr <= '0;
        end

        ST_FETCH: begin
          auto_tmr <= '0;
          // A press during a fetch is remembered once. Later presses while a
          // press is already remembered are dropped.
          if (btn_adv) begin
            pending <= 1'b1;
          end
          if (conv_ack) begin
            dots_out <= conv_dots;
            char_idx <= conv_idx;
            conv_req <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (advance) begin
            if (conv_idx == IDX_LAST) begin
              conv_idx <= '0;
              wrap     <= 1'b1;
            end else begin
              conv_idx <= conv_idx + IDX_W'(1);
            end
            pending  <= 1'b0;
            conv_req <= 1'b1;
            busy     <= 1'b1;
            auto_tmr <= '0;
            state    <= ST_FETCH;
          end else if (auto_en) begin
            auto_tmr <= auto_tmr + TM_W'(1);
          end else begin
            auto_tmr <= '0;
          end
        end

        default: begin
          state    <= ST_RESET;
          conv_req <= 1'b0;
          busy     <= 1'b0;
          pending  <= 1'b0;
          auto_tmr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_braille_reader_sequencer.sv
`timescale 1ns/1ps
module tb_braille_reader_sequencer;

  localparam int DEB = 16;
  localparam int LEN = 16;
  localparam int IW  = 4;
  localparam int AP  = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          next_btn = 1'b0;
  logic          auto_en = 1'b0;
  logic          conv_ack = 1'b0;
  logic [5:0]    conv_dots = '0;
  logic          conv_req;
  logic [IW-1:0] conv_idx;
  logic [5:0]    dots_out;
  logic [IW-1:0] char_idx;
  logic          busy;
  logic          wrap;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  braille_reader_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .MSG_LEN        (LEN),
    .IDX_W          (IW),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .next_btn (next_btn),
    .auto_en  (auto_en),
    .conv_req (conv_req),
    .conv_idx (conv_idx),
    .conv_ack (conv_ack),
    .conv_dots(conv_dots),
    .dots_out (dots_out),
    .char_idx (char_idx),
    .busy     (busy),
    .wrap     (wrap),
    .state_dbg(state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Converter responder: acks ack_dly cycles after it first sees conv_req
  // ---------------------------------------------------------------------------
  int         ack_dly = 0;
  int         wait_cnt = 0;
  bit         spurious_en = 1'b0;
  bit         fix_dots_en = 1'b0;
  logic [5:0] fix_dots = '0;
  logic [5:0] exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      conv_ack = 1'b0;
      if (!rst_n || !conv_req) begin
        wait_cnt = 0;
        if (rst_n && spurious_en && $urandom_range(0, 5) == 0) begin
          conv_ack  = 1'b1;
          conv_dots = 6'($urandom);
        end
      end else if (wait_cnt >= ack_dly) begin
        conv_ack  = 1'b1;
        conv_dots = fix_dots_en ? fix_dots : 6'($urandom);
        exp_q.push_back(conv_dots);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model, stepped once per rising edge.
  // Button: the debounced level follows the synced level once the synced
  // level has held one value, different from the debounced one, for DEB
  // samples. A press is visible to the sequencer one edge after that.
  // Sequencer: fetching / showing with a one-deep remembered press.
  // ---------------------------------------------------------------------------
  logic       mp1, mp2, m_prev_sv, m_deb, m_adv, m_sv, m_adv_use;
  int         m_age;
  bit         m_started, m_fetch, m_pending, m_wrap;
  int         m_idx, m_char, m_show_age;
  logic [5:0] m_dots;

  task automatic model_reset();
    mp1 = 0; mp2 = 0; m_prev_sv = 0; m_deb = 0; m_adv = 0; m_age = 0;
    m_started = 0; m_fetch = 0; m_pending = 0; m_wrap = 0;
    m_idx = 0; m_char = 0; m_show_age = 0; m_dots = '0;
  endtask

  task automatic model_step();
    m_adv_use = m_adv;
    m_sv = mp2;
    mp2  = mp1;
    mp1  = next_btn;
    if (m_sv == m_prev_sv) m_age++;
    else m_age = 1;
    m_prev_sv = m_sv;
    m_adv = 1'b0;
    if (m_sv != m_deb && m_age >= DEB) begin
      m_deb = m_sv;
      m_adv = m_sv;
    end
    m_wrap = 0;
    if (!m_started) begin
      m_started = 1;
      m_fetch   = 1;
      m_idx     = 0;
    end else if (m_fetch) begin
      if (m_adv_use) m_pending = 1;
      if (conv_ack) begin
        m_dots     = conv_dots;
        m_char     = m_idx;
        m_fetch    = 0;
        m_show_age = 0;
      end
    end else begin
      if (m_adv_use || m_pending || (auto_en && m_show_age == AP - 1)) begin
        m_idx     = (m_idx + 1) % LEN;
        m_wrap    = (m_idx == 0);
        m_pending = 0;
        m_fetch   = 1;
      end else begin
        m_show_age = auto_en ? m_show_age + 1 : 0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic prev_busy = 1'b0;
  logic prev_req  = 1'b0;
  int   cyc = 0;
  int   wrap_cnt = 0;
  int   req_rises = 0;
  int   last_rise = 0;
  int   req_gap = 0;

  task automatic monitor_step();
    cyc++;
    check_eq("conv_req", 32'(conv_req), 32'(m_fetch));
    check_eq("busy",     32'(busy),     32'(m_fetch));
    check_eq("conv_idx", 32'(conv_idx), 32'(m_idx));
    check_eq("dots_out", 32'(dots_out), 32'(m_dots));
    check_eq("char_idx", 32'(char_idx), 32'(m_char));
    check_eq("wrap",     32'(wrap),     32'(m_wrap));
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        check_eq("dots_q_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) check_eq("dots_q", 32'(dots_out), 32'(exp_q.pop_front()));
      end
      if (wrap) wrap_cnt++;
      if (conv_req && !prev_req) begin
        req_gap   = cyc - last_rise;
        last_rise = cyc;
        req_rises++;
      end
      prev_busy = busy;
      prev_req  = conv_req;
    end
  endtask

  always @(negedge clk) monitor_step();

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic press(input int hold, input int gap, input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 8; i++) begin
        next_btn = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    next_btn = 1'b1;
    repeat (hold) @(negedge clk);
    if (bounce) begin
      for (int i = 0; i < 6; i++) begin
        next_btn = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    next_btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'(lvl));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int start_idx, w0, r0, bc;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_conv_req", 32'(conv_req), 32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_dots",     32'(dots_out), 32'd0);

    // 1: first fetch, ack after 3 busy cycles with dots 01
    ack_dly = 2; fix_dots_en = 1; fix_dots = 6'h01;
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "t1_busy_rise");
    check_eq("t1_conv_idx", 32'(conv_idx), 32'd0);
    bc = 0;
    while (busy && bc < 50) begin
      @(negedge clk);
      bc++;
    end
    check_eq("t1_busy_cycles", 32'(bc), 32'd3);
    check_eq("t1_dots_out", 32'(dots_out), 32'h01);
    check_eq("t1_char_idx", 32'(char_idx), 32'd0);
    fix_dots_en = 0; ack_dly = 1;

    // 2: bouncing press then steady hold gives one advance
    repeat (5) @(negedge clk);
    start_idx = int'(conv_idx);
    r0 = req_rises;
    for (int i = 0; i < 10; i++) begin
      next_btn = 1'(i % 2);
      @(negedge clk);
    end
    next_btn = 1'b1;
    repeat (40) @(negedge clk);
    next_btn = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("t2_idx", 32'(conv_idx), 32'((start_idx + 1) % LEN));
    check_eq("t2_fetches", 32'(req_rises - r0), 32'd1);

    // 3: walk up to the last index, then wrap
    for (int i = 0; i < 20 && conv_idx != IW'(LEN - 1); i++) press(24, 24, 1'b1);
    check_eq("t3_at_last", 32'(conv_idx), 32'(LEN - 1));
    w0 = wrap_cnt;
    press(24, 24, 1'b0);
    check_eq("t3_wrap_idx", 32'(conv_idx), 32'd0);
    check_eq("t3_wrap_pulses", 32'(wrap_cnt - w0), 32'd1);

    // 4: auto-advance with immediate acks, then presses near expiry
    ack_dly = 0;
    auto_en = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("t4_period", 32'(req_gap), 32'(AP + 1));
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      press(20, 20, 1'b0);
    end
    auto_en = 1'b0;
    repeat (20) @(negedge clk);

    // 5: two presses during one long fetch leave one remembered advance
    ack_dly = 100;
    start_idx = int'(conv_idx);
    r0 = req_rises;
    press(20, 20, 1'b0);
    press(20, 20, 1'b0);
    press(20, 20, 1'b0);
    repeat (300) @(negedge clk);
    check_eq("t5_idx", 32'(conv_idx), 32'((start_idx + 2) % LEN));
    check_eq("t5_fetches", 32'(req_rises - r0), 32'd2);

    // 6: reset in the middle of fetching index 5
    ack_dly = 1;
    for (int i = 0; i < 20 && conv_idx != IW'(4); i++) press(24, 24, 1'b0);
    ack_dly = 50;
    press(24, 4, 1'b0);
    check_eq("t6_fetch_idx", 32'(conv_idx), 32'd5);
    check_eq("t6_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_req",  32'(conv_req), 32'd0);
    check_eq("t6_async_idx",  32'(conv_idx), 32'd0);
    check_eq("t6_async_dots", 32'(dots_out), 32'd0);
    check_eq("t6_async_char", 32'(char_idx), 32'd0);
    check_eq("t6_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    ack_dly = 1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_restart_req", 32'(conv_req), 32'd1);
    check_eq("t6_restart_idx", 32'(conv_idx), 32'd0);
    repeat (10) @(negedge clk);

    // Random traffic: short and long presses, bounces, auto toggling,
    // random ack latency and acks while not fetching
    spurious_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ack_dly = $urandom_range(0, 12);
      auto_en = 1'($urandom_range(0, 1));
      press($urandom_range(5, 40), $urandom_range(5, 40), 1'($urandom_range(0, 1)));
    end
    spurious_en = 1'b0;
    auto_en = 1'b0;
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
